// File: rtl/mse_accumulator.sv
// ---------------------------------------------------------------------------
// mse_accumulator
//
// Streaming error-metric sink. Accepts one (exact, approximate) sample pair
// per cycle, accumulates the sum of squared errors over a block of
// 2**N_LOG2 pairs, then publishes SSE and MSE (SSE >> N_LOG2).
//
// Ports
//   clk       in   1      rising-edge clock
//   rstN      in   1      asynchronous active-low reset
//   start     in   1      begin a new block (only honoured in IDLE)
//   in_valid  in   1      y_ref / y_apx valid this cycle
//   in_ready  out  1      block is accepting samples (RUN)
//   y_ref     in   W      exact-filter sample, signed
//   y_apx     in   W      approximate-filter sample, signed
//   busy      out  1      RUN, DRAIN or DONE
//   done      out  1      one-cycle pulse when sse/mse are updated
//   sse       out  ACC_W  sum of squared errors of the last block
//   mse       out  2*W    sse >> N_LOG2, floor
//   ovf       out  1      accumulator saturated during the last block
// ---------------------------------------------------------------------------
module mse_accumulator #(
    parameter int W      = 16,
    parameter int N_LOG2 = 10,
    parameter int ACC_W  = 2*W + N_LOG2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  y_ref,
    input  logic signed [W-1:0]  y_apx,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     sse,
    output logic [2*W-1:0]       mse,
    output logic                 ovf
);

    // One spare bit over the wider addend catches the carry that signals saturation.
    localparam int SUM_W = ((ACC_W > 2*W) ? ACC_W : 2*W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [1:0]            r_drain;
    logic [N_LOG2-1:0]     r_cnt;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [ACC_W-1:0]      r_sse;
    logic [2*W-1:0]        r_mse;

    logic                  r_d_vld;
    logic signed [W:0]     r_d;
    logic                  r_sq_vld;
    logic [2*W-1:0]        r_sq;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_clr;
    logic signed [W:0]     w_diff;
    logic signed [2*W+1:0] w_d_ext;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_sat;
    logic [ACC_W-1:0]      w_mse_full;

    assign w_accept   = in_valid & r_in_ready;
    assign w_clr      = (r_state == S_IDLE) & start;
    // Sign-extend both operands so the difference is exact in W+1 bits.
    assign w_diff     = {y_ref[W-1], y_ref} - {y_apx[W-1], y_apx};
    assign w_d_ext    = (2*W+2)'(r_d);
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(r_sq);
    assign w_sat      = |(w_sum >> ACC_W);
    assign w_mse_full = r_acc >> N_LOG2;

    // Control FSM; all outputs registered.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_drain    <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sse      <= '0;
            r_mse      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                            r_drain    <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final accumulate lands on the second drain edge; the third
                    // edge moves on so done appears 4 edges after the last accept.
                    if (r_drain == 2'd2) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_sse   <= r_acc;
                    r_mse   <= (2*W)'(w_mse_full);
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: diff -> square -> saturating accumulate, each with a valid bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_d_vld  <= 1'b0;
            r_d      <= '0;
            r_sq_vld <= 1'b0;
            r_sq     <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_d_vld  <= w_accept;
            r_sq_vld <= r_d_vld;
            if (w_accept) begin
                r_d <= w_diff;
            end
            if (r_d_vld) begin
                // |d| <= 2**W-1, so the square always fits in 2*W bits.
                r_sq <= (2*W)'(w_d_ext * w_d_ext);
            end
            if (w_clr) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_sq_vld) begin
                if (w_sat) begin
                    r_acc <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= ACC_W'(w_sum);
                end
            end
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sse      = r_sse;
    assign mse      = r_mse;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_mse_accumulator.sv
module tb_mse_accumulator;

    localparam int W = 16;
    localparam int NL = 2;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rstN, start, in_valid;
    logic signed [W-1:0] y_ref, y_apx;

    logic in_ready, busy, done, ovf;
    logic [2*W+NL-1:0] sse;
    logic [2*W-1:0] mse;

    logic in_ready33, busy33, done33, ovf33;
    logic [32:0] sse33;
    logic [2*W-1:0] mse33;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mse_accumulator #(.W(W), .N_LOG2(NL)) dut (
        .clk(clk), .rstN(rstN), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .y_ref(y_ref), .y_apx(y_apx), .busy(busy), .done(done), .sse(sse), .mse(mse), .ovf(ovf)
    );

    mse_accumulator #(.W(W), .N_LOG2(NL), .ACC_W(33)) dut33 (
        .clk(clk), .rstN(rstN), .start(start), .in_valid(in_valid), .in_ready(in_ready33),
        .y_ref(y_ref), .y_apx(y_apx), .busy(busy33), .done(done33), .sse(sse33), .mse(mse33), .ovf(ovf33)
    );

    typedef struct {
        logic [NP-1:0][W-1:0] rv;
        logic [NP-1:0][W-1:0] av;
        longint e_sse;
        longint e_mse;
        bit     e_ovf;
        longint e_sse33;
        longint e_mse33;
        bit     e_ovf33;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain sum of squared differences, clamped to the accumulator range.
    function automatic longint model_sse(input logic [NP-1:0][W-1:0] rv,
                                         input logic [NP-1:0][W-1:0] av,
                                         input int accw, output bit o);
        longint s = 0;
        longint lim = (longint'(1) << accw) - 1;
        for (int i = 0; i < NP; i++) begin
            longint d = longint'($signed(rv[i])) - longint'($signed(av[i]));
            s += d * d;
        end
        o = (s > lim);
        return o ? lim : s;
    endfunction

    task automatic run_block(input string nm, input logic [NP-1:0][W-1:0] rv,
                             input logic [NP-1:0][W-1:0] av, input int gap_max, input bit pulse,
                             input longint e_sse, input longint e_mse, input bit e_ovf,
                             input longint e_sse33, input longint e_mse33, input bit e_ovf33);
        int lat = 0;
        int extra = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = pulse;
        chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
        chk({nm, " busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < NP; i++) begin
            int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0; y_ref = W'($urandom); y_apx = W'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1; y_ref = rv[i]; y_apx = av[i];
            @(negedge clk);
        end
        in_valid = 1'b0; y_ref = W'($urandom); y_apx = W'($urandom);
        for (int j = 1; j <= 12 && lat == 0; j++) begin
            start = pulse && (j < 3);
            @(negedge clk);
            if (done) lat = j;
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(lat), 64'd4);
        chk({nm, " sse"}, 64'(sse), 64'(e_sse));
        chk({nm, " mse"}, 64'(mse), 64'(e_mse));
        chk({nm, " ovf"}, 64'(ovf), 64'(e_ovf));
        chk({nm, " sse33"}, 64'(sse33), 64'(e_sse33));
        chk({nm, " mse33"}, 64'(mse33), 64'(e_mse33));
        chk({nm, " ovf33"}, 64'(ovf33), 64'(e_ovf33));
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk({nm, " single_done_idle"}, 64'(extra), 64'd0);
    endtask

    task automatic run_rand(input string nm, input int gap_max);
        logic [NP-1:0][W-1:0] rv, av;
        bit o34, o33;
        longint s34, s33;
        for (int i = 0; i < NP; i++) begin
            rv[i] = W'($urandom);
            av[i] = W'($urandom);
        end
        s34 = model_sse(rv, av, 2*W+NL, o34);
        s33 = model_sse(rv, av, 33, o33);
        run_block(nm, rv, av, gap_max, 1'b0, s34, (s34 >> NL) & 64'hFFFF_FFFF, o34,
                  s33, (s33 >> NL) & 64'hFFFF_FFFF, o33);
    endtask

    initial begin
        int ndone, first_c, cnt;

        tab[0] = '{rv: {4{16'd1234}}, av: {4{16'd1234}}, e_sse: 0, e_mse: 0, e_ovf: 0,
                   e_sse33: 0, e_mse33: 0, e_ovf33: 0};
        tab[1] = '{rv: {4{16'd100}}, av: {4{16'd97}}, e_sse: 36, e_mse: 9, e_ovf: 0,
                   e_sse33: 36, e_mse33: 9, e_ovf33: 0};
        tab[2] = '{rv: {4{16'h7FFF}}, av: {4{16'h8000}}, e_sse: 64'd17179344900,
                   e_mse: 64'd4294836225, e_ovf: 0,
                   e_sse33: 64'd8589934591, e_mse33: 64'd2147483647, e_ovf33: 1};
        tab[3] = '{rv: {4{16'd7}}, av: {4{16'd7}}, e_sse: 0, e_mse: 0, e_ovf: 0,
                   e_sse33: 0, e_mse33: 0, e_ovf33: 0};
        tab[4] = '{rv: {16'd4, 16'd3, 16'd2, 16'd1}, av: {4{16'd0}}, e_sse: 30, e_mse: 7,
                   e_ovf: 0, e_sse33: 30, e_mse33: 7, e_ovf33: 0};

        rstN = 1'b0; start = 1'b0; in_valid = 1'b0; y_ref = '0; y_apx = '0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst sse", 64'(sse), 0);
        chk("rst mse", 64'(mse), 0);
        chk("rst ovf", 64'(ovf), 0);
        rstN = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++)
            run_block($sformatf("tab%0d", t), tab[t].rv, tab[t].av, 0, 1'b0,
                      tab[t].e_sse, tab[t].e_mse, tab[t].e_ovf,
                      tab[t].e_sse33, tab[t].e_mse33, tab[t].e_ovf33);

        // Same 100/97 block with idle gaps between pairs.
        run_block("gaps", tab[1].rv, tab[1].av, 3, 1'b0, 36, 9, 0, 36, 9, 0);

        // start pulsed during RUN and DRAIN must not disturb the block.
        run_block("start_pulse", tab[4].rv, tab[4].av, 1, 1'b1, 30, 7, 0, 30, 7, 0);

        // start held high: two back-to-back blocks, each with its own done.
        ndone = 0; first_c = -10;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; y_ref = 16'd100; y_apx = 16'd97;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) first_c = c;
                chk($sformatf("held sse%0d", ndone), 64'(sse), 36);
            end
            if (c == first_c + 1) start = 1'b0;
        end
        start = 1'b0; in_valid = 1'b0;
        chk("held done_count", 64'(ndone), 2);

        for (int r = 0; r < 6; r++) run_rand($sformatf("rand%0d", r), r % 3);

        // Reset in the middle of a block.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; y_ref = 16'd500; y_apx = -16'sd500;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("mid busy", 64'(busy), 1);
        rstN = 1'b0;
        #1;
        chk("mid_rst in_ready", 64'(in_ready), 0);
        chk("mid_rst busy", 64'(busy), 0);
        chk("mid_rst done", 64'(done), 0);
        chk("mid_rst sse", 64'(sse), 0);
        chk("mid_rst mse", 64'(mse), 0);
        chk("mid_rst ovf33", 64'(ovf33), 0);
        @(negedge clk); rstN = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mid_rst no_done", 64'(cnt), 0);
        run_rand("after_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
